// File: rtl/uart_rx_rtl.sv
// 8N1 UART receiver: synchronises rxd, samples each bit at mid-bit and hands
// received bytes to a valid/ready consumer, flagging framing errors and overruns.
module uart_rx_rtl #(
  parameter int unsigned CLK_FREQUENCY = 50_000_000,
  parameter int unsigned BAUD_RATE     = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned BAUD_CNT_MAX = CLK_FREQUENCY / BAUD_RATE - 1;
  localparam int unsigned HALF_CNT     = BAUD_CNT_MAX / 2;
  localparam int unsigned CNT_W        = (BAUD_CNT_MAX > 0) ? $clog2(BAUD_CNT_MAX + 1) : 1;
  localparam int unsigned IDX_W        = 3;
  localparam int unsigned DATA_W       = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic                rxd_meta, rxd_s, rxd_prev;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic [DATA_W-1:0]   shift, shift_nxt;
  logic                fall_c;
  logic                cnt_max_c;
  logic                cnt_half_c;
  logic                byte_done_c;
  logic                stop_bad_c;

  // Two-flop synchroniser plus previous-sample flop for start-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
      rxd_prev <= rxd_s;
    end
  end

  assign fall_c     = rxd_prev & ~rxd_s;
  assign cnt_max_c  = (cnt == CNT_W'(BAUD_CNT_MAX));
  assign cnt_half_c = (cnt == CNT_W'(HALF_CNT));

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      shift <= shift_nxt;
    end
  end

  // Next-state and frame decode
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    idx_nxt     = idx;
    shift_nxt   = shift;
    byte_done_c = 1'b0;
    stop_bad_c  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (fall_c) begin
          state_nxt = START;
        end
      end
      START: begin
        if (cnt_half_c) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = rxd_s ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_max_c) begin
          cnt_nxt   = '0;
          shift_nxt = {rxd_s, shift[DATA_W-1:1]};
          idx_nxt   = idx + IDX_W'(1);
          if (idx == IDX_W'(DATA_W - 1)) begin
            state_nxt = STOP;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        // Back to IDLE at mid-stop so an immediately following start edge is caught
        if (cnt_max_c) begin
          cnt_nxt     = '0;
          state_nxt   = IDLE;
          byte_done_c = rxd_s;
          stop_bad_c  = ~rxd_s;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output holding register with valid/ready handshake and overrun detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad_c;
      overrun   <= 1'b0;
      if (byte_done_c) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
